// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 round-key streamer.
//   NUM_RK     : number of round keys in an AES-256 schedule
//   RK_W       : width of one round key in bits
//   rk_state_t : streamer FSM states
//   rk_idx_t   : round-key index (0..14)
package aes_pkg;

   localparam int NUM_RK = 15;
   localparam int RK_W   = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } rk_state_t;

   typedef logic [3:0] rk_idx_t;

   localparam rk_idx_t LAST_IDX = rk_idx_t'(NUM_RK - 1);

endpackage

// File: rtl/aes_round_key_streamer.sv
// aes_round_key_streamer
// Waits out the key-expansion pipeline latency after a key launch, captures
// the whole 15-key AES-256 schedule, then serves keys 0..14 in order to the
// cipher round unit. A rewind replays the captured schedule from key 0
// without resampling the key-expansion output.
//
// Ports:
//   clk_i        in   clock, rising edge
//   reset_i      in   synchronous active-high reset
//   start_i      in   key launched this cycle; (re)enter the latency wait
//   round_keys_i in   schedule, key 0 in the most significant 128 bits
//   rewind_i     in   restart streaming from key 0 (STREAM/DONE only)
//   rk_o         out  current round key
//   rk_idx_o     out  index of rk_o
//   rk_last_o    out  rk_o is key 14 and valid
//   v_o          out  rk_o valid
//   ready_i      in   consumer accepts rk_o
//   busy_o       out  waiting for the schedule
//   done_o       out  all 15 keys transferred since capture/rewind
//   state_o      out  FSM state, for observation
//
// Handshake: a key transfers on a rising edge where v_o & ready_i are both
// high. While v_o is high and ready_i is low, rk_o, rk_idx_o and v_o hold.
// No output depends combinationally on ready_i.
module aes_round_key_streamer
   import aes_pkg::*;
#(
   // Cycles from key launch until round_keys_i is valid; must be >= 1.
   parameter int EXP_LATENCY = 7
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic [NUM_RK*RK_W-1:0] round_keys_i,
   input  logic                   rewind_i,
   output logic [RK_W-1:0]        rk_o,
   output logic [3:0]             rk_idx_o,
   output logic                   rk_last_o,
   output logic                   v_o,
   input  logic                   ready_i,
   output logic                   busy_o,
   output logic                   done_o,
   output rk_state_t              state_o
);

   localparam int CNT_W = $clog2(EXP_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXP_LATENCY - 1);

   rk_state_t                 state, state_n;
   logic [CNT_W-1:0]          cnt, cnt_n;
   rk_idx_t                   idx, idx_n;
   logic [NUM_RK*RK_W-1:0]    sched;
   logic                      capture;
   logic [RK_W-1:0]           rk_sel;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sched <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         if (capture) begin
            sched <= round_keys_i;
         end
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      capture = 1'b0;
      if (start_i) begin
         // A new launch abandons whatever was in flight, in any state;
         // a coincident transfer or rewind is dropped.
         state_n = WAIT;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
            end
            WAIT: begin
               if (cnt == CNT_LAST) begin
                  capture = 1'b1;
                  idx_n   = '0;
                  cnt_n   = '0;
                  state_n = STREAM;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            STREAM: begin
               // Rewind wins over a coincident transfer.
               if (rewind_i) begin
                  idx_n = '0;
               end else if (ready_i) begin
                  if (idx == LAST_IDX) begin
                     state_n = DONE;
                  end else begin
                     idx_n = idx + rk_idx_t'(1);
                  end
               end
            end
            DONE: begin
               if (rewind_i) begin
                  idx_n   = '0;
                  state_n = STREAM;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Key i occupies the i-th 128-bit slice counted from the MSB end.
   always_comb begin
      rk_sel = '0;
      for (int i = 0; i < NUM_RK; i++) begin
         if (idx == rk_idx_t'(i)) begin
            rk_sel = sched[(NUM_RK-1-i)*RK_W +: RK_W];
         end
      end
   end

   assign rk_o      = rk_sel;
   assign rk_idx_o  = idx;
   assign v_o       = (state == STREAM);
   assign busy_o    = (state == WAIT);
   assign done_o    = (state == DONE);
   assign rk_last_o = (state == STREAM) && (idx == LAST_IDX);
   assign state_o   = state;

endmodule

// File: doc/aes_round_key_streamer.md
# aes_round_key_streamer

Buffers the 15 AES-256 round keys produced by the pipelined key expansion and streams them, one 128-bit key per handshake, into the iterative cipher round unit. It sits directly downstream of the key expansion stage. It waits out that stage's fixed pipeline latency after a new key is launched, captures the full schedule, and serves keys 0..14 in order. On request it rewinds, so every new data block reuses the same captured schedule.

## Interface
- EXP_LATENCY, 7: cycles from key launch until the key expansion output is valid; must be ≥1.
- NUM_RK, 15: number of round keys in the schedule.
- RK_W, 128: round key width in bits.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; the key on the key expansion input is launched this cycle.
- round_keys_i  in  NUM_RK*RK_W  schedule from key expansion, bit-indexed [0:1919]; key i = bits [128*i : 128*i+127], bit 0 is MSB.
- rewind_i  in  1  restart streaming from key 0 of the captured schedule.
- rk_o  out  RK_W  current round key.
- rk_idx_o  out  4  index of rk_o, 0..14.
- rk_last_o  out  1  high when rk_idx_o == 14 and v_o is high.
- v_o  out  1  rk_o is valid.
- ready_i  in  1  consumer accepts rk_o; a transfer occurs when v_o & ready_i.
- busy_o  out  1  high while waiting for the schedule (WAIT state).
- done_o  out  1  all 15 keys have been transferred since the last capture or rewind.

## Operation
- States: IDLE (no schedule), WAIT (latency count), STREAM (presenting keys), DONE (schedule exhausted and held).
- IDLE: outputs are low. start_i moves to WAIT with cnt=0. rewind_i has no effect.
- WAIT: cnt increments each cycle. When cnt == EXP_LATENCY-1, capture round_keys_i into a 1920-bit register, set idx=0 and go to STREAM. Upstream holds the initial key stable from start_i through capture.
- STREAM: v_o=1, rk_o = captured key[idx]. Each transfer increments idx. A transfer at idx 14 goes to DONE.
- DONE: v_o=0, done_o=1. The captured schedule is retained. rewind_i sets idx=0 and goes to STREAM.
- Priority within one cycle: reset_i > start_i > rewind_i > transfer.
- start_i in any state, including mid-WAIT and mid-STREAM: drop v_o next cycle, clear cnt, re-enter WAIT, and discard the in-flight key index. A transfer in the same cycle is ignored.
- rewind_i in STREAM: idx=0 next cycle and v_o stays high. A coincident transfer is not counted.
- rewind_i in WAIT: ignored.
- rk_o, rk_idx_o and rk_last_o are registered or derived from registered state only; no combinational path from ready_i to any output.
- Width rules:
  - cnt is $clog2(EXP_LATENCY+1) bits.
  - idx is 4 bits and never exceeds 14; there is no wrap past 14, only DONE.

## Timing
- Reset values: v_o=0, rk_last_o=0, busy_o=0, done_o=0, rk_idx_o=0, rk_o=0, state=IDLE, captured schedule cleared.
- start_i high at cycle t:
  - busy_o is high in cycles t+1..t+EXP_LATENCY.
  - round_keys_i is sampled at the edge ending cycle t+EXP_LATENCY.
  - v_o is high with idx 0 from cycle t+EXP_LATENCY+1.
- With ready_i held high: one key per cycle; 15 transfers take 15 consecutive cycles; done_o rises the cycle after the idx-14 transfer.
- ready_i low: rk_o, rk_idx_o and v_o are held unchanged.
- rewind_i in DONE at cycle r: v_o high with idx 0 in cycle r+1.
- reset_i mid-operation: next cycle matches the reset values; a new start_i is required.

## Structure
- Shared package aes_pkg: NUM_RK, RK_W, the state enum {IDLE, WAIT, STREAM, DONE}, and the round-key index type (4 bits).
- The captured schedule is a packed NUM_RK*RK_W register. Key select is a 15:1 mux on idx.
- No sub-module; the FSM, counter and mux live in this single module (roughly 150–200 lines).

## Test plan
- Reset, then drive round_keys_i with key i = 16 bytes of value i. Pulse start_i and hold ready_i=1 → v_o rises exactly 8 cycles after start_i. rk_o takes 00..00, 0101..01, …, 0e0e..0e on consecutive cycles. rk_last_o is high only with 0e..0e. done_o=1 the following cycle.
- Same stimulus with ready_i toggling 1,0,0,1,… → no key is skipped or duplicated, rk_o is stable while ready_i=0, and exactly 15 transfers occur.
- After DONE, change round_keys_i to all-FF, then pulse rewind_i → the original pattern 00..00..0e..0e is replayed (the buffer is not resampled).
- Pulse start_i at idx 5 with a new pattern (key i = value 0x20+i) → v_o is low for 7 cycles, busy_o is high, then the stream restarts at 2020..20.
- Assert rewind_i and a transfer together at idx 9 → next cycle idx=0 with v_o=1; total transfers are still counted from 0.
- Assert reset_i at idx 3, holding start_i and rewind_i high in the same cycle → the next cycle has all outputs 0 and state IDLE.
